// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode constants and issue-stage operand selects.
// Consumed by the issue stage and the ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_AND  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    A_ZERO,
    A_RS1,
    A_PC
  } a_sel_e;

  typedef enum logic [1:0] {
    B_ZERO,
    B_RS2,
    B_IMM,
    B_RS2_SHAMT
  } b_sel_e;

  // alt selects SUB over ADD and SRA over SRL; ignored for the other funct3 values
  function automatic alu_op_e op_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decoder: instruction word to op, operand
// selects, immediate, register indices, write enable and illegal flag.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_e     alu_op,
  output a_sel_e      a_sel,
  output b_sel_e      b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic        reg_write,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd       = instr[11:7];
  assign rs1_idx  = instr[19:15];
  assign rs2_idx  = instr[24:20];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    alu_op  = ALU_ADD;
    a_sel   = A_ZERO;
    b_sel   = B_ZERO;
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OP: begin
        if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) begin
          alu_op = op_from_funct3(funct3, funct7[5]);
          a_sel  = A_RS1;
          if (is_shift) b_sel = B_RS2_SHAMT;
          else          b_sel = B_RS2;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        // only the shift encodings carry funct7; SLLI has no arithmetic variant
        if (((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
            ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))) begin
          illegal = 1'b1;
        end else begin
          alu_op = op_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
          a_sel  = A_RS1;
          b_sel  = B_IMM;
          if (is_shift) imm = {27'b0, instr[24:20]};
          else          imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      LUI: begin
        b_sel = B_IMM;
        imm   = {instr[31:12], 12'b0};
      end
      AUIPC: begin
        a_sel = A_PC;
        b_sel = B_IMM;
        imm   = {instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign reg_write = !illegal && (rd != 5'd0);

endmodule

// File: rtl/ex_issue.sv
// Issue stage: one pipeline register between decode and the ALU, with
// operand selection, x0 zeroing and optional writeback forwarding
// (enabled by defining EX_ISSUE_FORWARD_EN).
module ex_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_bypass,
  input  logic [31:0] rd_data_bypass,
  input  logic        reg_write_bypass,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  alu_op_e     dec_op;
  a_sel_e      dec_a_sel;
  b_sel_e      dec_b_sel;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        dec_reg_write;
  logic        dec_illegal;

  alu_decode u_decode (
    .instr     (instr),
    .alu_op    (dec_op),
    .a_sel     (dec_a_sel),
    .b_sel     (dec_b_sel),
    .imm       (dec_imm),
    .rd        (dec_rd),
    .rs1_idx   (rs1_idx),
    .rs2_idx   (rs2_idx),
    .reg_write (dec_reg_write),
    .illegal   (dec_illegal)
  );

  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

`ifdef EX_ISSUE_FORWARD_EN
  always_comb begin
    rs1_fwd = rs1_data;
    rs2_fwd = rs2_data;
    if (reg_write_bypass && (rd_bypass != 5'd0) && (rd_bypass == rs1_idx)) rs1_fwd = rd_data_bypass;
    if (reg_write_bypass && (rd_bypass != 5'd0) && (rd_bypass == rs2_idx)) rs2_fwd = rd_data_bypass;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{rd_bypass, rd_data_bypass, reg_write_bypass};
  assign rs1_fwd = rs1_data;
  assign rs2_fwd = rs2_data;
`endif

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign rs1_val = (rs1_idx == 5'd0) ? '0 : rs1_fwd;
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : rs2_fwd;

  always_comb begin
    case (dec_a_sel)
      A_RS1:   op_a = rs1_val;
      A_PC:    op_a = pc;
      default: op_a = '0;
    endcase
    case (dec_b_sel)
      B_RS2:       op_b = rs2_val;
      B_IMM:       op_b = dec_imm;
      B_RS2_SHAMT: op_b = {27'b0, rs2_val[4:0]};
      default:     op_b = '0;
    endcase
  end

  logic        valid_q, valid_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  alu_op_e     alu_op_q, alu_op_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        illegal_q, illegal_d;
  logic        accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // flush dominates; otherwise a load may coincide with the drain of the held entry
  always_comb begin
    valid_d     = valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      alu_a_d     = op_a;
      alu_b_d     = op_b;
      alu_op_d    = dec_op;
      rd_d        = dec_rd;
      reg_write_d = dec_reg_write;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_ADD;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rd        = rd_q;
  assign reg_write = reg_write_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ex_issue.sv
// Bench for ex_issue: fixed vector table, handshake/flush/reset sequences and
// a randomized run against a behavioural model of the issue stage.
module tb_ex_issue;

`ifdef EX_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [4:0]  rd_bypass;
  logic [31:0] rd_data_bypass;
  logic        reg_write_bypass;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;

  always #5 clk = ~clk;

  ex_issue dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instr            (instr),
    .pc               (pc),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .rd_bypass        (rd_bypass),
    .rd_data_bypass   (rd_data_bypass),
    .reg_write_bypass (reg_write_bypass),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_op           (alu_op),
    .rd               (rd),
    .reg_write        (reg_write),
    .illegal          (illegal)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc, r1, r2;
    logic [4:0]  brd;
    logic [31:0] bdat;
    logic        bwe;
    exp_t        e;
  } vec_t;

  // Reference: numeric op codes ADD=0 SUB=1 SLL=2 XOR=3 OR=4 AND=5 SRL=6 SRA=7 SLT=8 SLTU=9
  function automatic logic [3:0] ref_op(input logic [2:0] f3, input logic alt);
    logic [3:0] t [8];
    t[0] = alt ? 4'd1 : 4'd0; t[1] = 4'd2; t[2] = 4'd8; t[3] = 4'd9;
    t[4] = 4'd3; t[5] = alt ? 4'd7 : 4'd6; t[6] = 4'd4; t[7] = 4'd5;
    return t[f3];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [4:0] brd, input logic [31:0] bdat,
                                      input logic bwe);
    exp_t r;
    logic [6:0] opc = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic [4:0] s1 = i[19:15];
    logic [4:0] s2 = i[24:20];
    logic [31:0] va = r1, vb = r2;
    logic shift = (f3 == 3'd1) || (f3 == 3'd5);
    if (FWD && bwe && brd != 0 && brd == s1) va = bdat;
    if (FWD && bwe && brd != 0 && brd == s2) vb = bdat;
    if (s1 == 0) va = 0;
    if (s2 == 0) vb = 0;
    r.v = 1'b1; r.rd = i[11:7]; r.ill = 1'b0; r.op = 0; r.a = 0; r.b = 0;
    if (opc == 7'h33) begin
      if (f7 != 7'h00 && f7 != 7'h20) r.ill = 1'b1;
      else begin
        r.op = ref_op(f3, f7[5]); r.a = va;
        r.b = shift ? (vb % 32) : vb;
      end
    end else if (opc == 7'h13) begin
      if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20)) r.ill = 1'b1;
      else begin
        r.op = ref_op(f3, f3 == 5 && f7[5]); r.a = va;
        r.b = shift ? 32'(s2) : 32'($signed(i) >>> 20);
      end
    end else if (opc == 7'h37) begin
      r.b = i & 32'hFFFF_F000;
    end else if (opc == 7'h17) begin
      r.a = p; r.b = i & 32'hFFFF_F000;
    end else r.ill = 1'b1;
    r.rw = !r.ill && r.rd != 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
    end
  endtask

  task automatic chk_out(input string t, input exp_t e, input bit all);
    chk({t, ".out_valid"}, 32'(out_valid), 32'(e.v));
    if (e.v || all) begin
      chk({t, ".alu_a"}, alu_a, e.a);
      chk({t, ".alu_b"}, alu_b, e.b);
      chk({t, ".alu_op"}, 32'(alu_op), 32'(e.op));
      chk({t, ".rd"}, 32'(rd), 32'(e.rd));
      chk({t, ".reg_write"}, 32'(reg_write), 32'(e.rw));
      chk({t, ".illegal"}, 32'(illegal), 32'(e.ill));
    end
  endtask

  function automatic exp_t mk_e(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic [4:0] d, input logic rw, input logic ill);
    exp_t e;
    e.v = 1'b1; e.a = a; e.b = b; e.op = op; e.rd = d; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mk_v(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [4:0] brd, input logic [31:0] bdat,
                                input logic bwe, input exp_t e);
    vec_t v;
    v.instr = i; v.pc = p; v.r1 = r1; v.r2 = r2; v.brd = brd; v.bdat = bdat; v.bwe = bwe; v.e = e;
    return v;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] brd, input logic [31:0] bdat,
                       input logic bwe);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
    rd_bypass = brd; rd_data_bypass = bdat; reg_write_bypass = bwe;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7;
    int unsigned k = $urandom_range(0, 5);
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k <= 1)      w = {f7, w[24:7], 7'h33};
    else if (k <= 3) w = {f7, w[24:7], 7'h13};
    else if (k == 4) w = {w[31:7], w[0] ? 7'h37 : 7'h17};
    return w;
  endfunction

  vec_t vt[$];
  exp_t zero_e, hold_e, m_e;
  logic m_v;

  initial begin
    zero_e = mk_e(0, 0, 0, 0, 0, 0);
    zero_e.v = 1'b0;

    vt.push_back(mk_v(32'h002081B3, 0, 5, 7, 0, 0, 0, mk_e(5, 7, 0, 3, 1, 0)));                         // add x3,x1,x2
    vt.push_back(mk_v(32'h4030D093, 0, 32'hFFFFFF00, 9, 0, 0, 0, mk_e(32'hFFFFFF00, 3, 7, 1, 1, 0)));    // srai
    vt.push_back(mk_v(32'hFFF00093, 0, 32'h1234, 0, 0, 0, 0, mk_e(0, 32'hFFFFFFFF, 0, 1, 1, 0)));        // addi x1,x0,-1
    vt.push_back(mk_v(32'h407302B3, 0, 10, 3, 0, 0, 0, mk_e(10, 3, 1, 5, 1, 0)));                        // sub
    vt.push_back(mk_v(32'h003110B3, 0, 32'h11, 32'hFFFFFF25, 0, 0, 0, mk_e(32'h11, 5, 2, 1, 1, 0)));     // sll
    vt.push_back(mk_v(32'h409453B3, 0, 32'h80000000, 32'hFFE3, 0, 0, 0, mk_e(32'h80000000, 3, 7, 7, 1, 0))); // sra
    vt.push_back(mk_v(32'h0062B233, 0, 1, 2, 0, 0, 0, mk_e(1, 2, 9, 4, 1, 0)));                          // sltu
    vt.push_back(mk_v(32'h7FF1C113, 0, 32'hAA, 0, 0, 0, 0, mk_e(32'hAA, 32'h7FF, 3, 2, 1, 0)));          // xori
    vt.push_back(mk_v(32'h12345137, 32'h40, 8, 8, 0, 0, 0, mk_e(0, 32'h12345000, 0, 2, 1, 0)));          // lui
    vt.push_back(mk_v(32'hABCDE217, 32'h100, 8, 8, 0, 0, 0, mk_e(32'h100, 32'hABCDE000, 0, 4, 1, 0)));   // auipc
    vt.push_back(mk_v(32'h00208033, 0, 5, 7, 0, 0, 0, mk_e(5, 7, 0, 0, 0, 0)));                          // add x0
    vt.push_back(mk_v(32'h000001B3, 0, 5, 7, 0, 0, 0, mk_e(0, 0, 0, 3, 1, 0)));                          // add x3,x0,x0
    vt.push_back(mk_v(32'h0000007F, 0, 5, 7, 0, 0, 0, mk_e(0, 0, 0, 0, 0, 1)));                          // bad opcode
    vt.push_back(mk_v(32'h022081B3, 0, 5, 7, 0, 0, 0, mk_e(0, 0, 0, 3, 0, 1)));                          // funct7=1 on OP
    vt.push_back(mk_v(32'h40309093, 0, 5, 7, 0, 0, 0, mk_e(0, 0, 0, 1, 0, 1)));                          // slli with bit30
    vt.push_back(mk_v(32'h002081B3, 0, 5, 7, 1, 32'hDEAD, 1, mk_e(FWD ? 32'hDEAD : 32'h5, 7, 0, 3, 1, 0))); // bypass rs1
    vt.push_back(mk_v(32'h002081B3, 0, 5, 7, 2, 32'hBEEF, 1, mk_e(5, FWD ? 32'hBEEF : 32'h7, 0, 3, 1, 0))); // bypass rs2
    vt.push_back(mk_v(32'h002081B3, 0, 5, 7, 0, 32'hDEAD, 1, mk_e(5, 7, 0, 3, 1, 0)));                   // bypass rd=0
    vt.push_back(mk_v(32'h002081B3, 0, 5, 7, 1, 32'hDEAD, 0, mk_e(5, 7, 0, 3, 1, 0)));                   // bypass disabled

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("reset", zero_e, 1'b1);
    chk("reset.in_ready", 32'(in_ready), 1);
    #18 reset = 1'b0;
    @(posedge clk); #1;
    chk_out("post_reset", zero_e, 1'b1);

    // vector table, back-to-back with out_ready=1
    out_ready = 1'b1;
    for (int unsigned n = 0; n < vt.size(); n++) begin
      in_valid = 1'b1;
      drive(vt[n].instr, vt[n].pc, vt[n].r1, vt[n].r2, vt[n].brd, vt[n].bdat, vt[n].bwe);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", n), vt[n].e, 1'b0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_out("drain", zero_e, 1'b0);

    // backpressure: held entry frozen, pending one taken on release without a bubble
    in_valid = 1'b1; drive(32'h002081B3, 0, 5, 7, 0, 0, 0);
    hold_e = mk_e(5, 7, 0, 3, 1, 0);
    @(posedge clk); #1;
    chk_out("bp.load", hold_e, 1'b0);
    out_ready = 1'b0; drive(32'h407302B3, 0, 10, 3, 0, 0, 0);
    for (int unsigned c = 0; c < 2; c++) begin
      #1 chk("bp.in_ready_low", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk_out($sformatf("bp.hold%0d", c), hold_e, 1'b0);
    end
    out_ready = 1'b1;
    #1 chk("bp.in_ready_high", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk_out("bp.second", mk_e(10, 3, 1, 5, 1, 0), 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_out("bp.drain", zero_e, 1'b0);

    // flush beats a simultaneous accept
    in_valid = 1'b1; drive(32'h002081B3, 0, 5, 7, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("fl.load", hold_e, 1'b0);
    out_ready = 1'b0; flush = 1'b1; drive(32'h407302B3, 0, 10, 3, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("fl.squash", zero_e, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // async reset while an entry is held under backpressure
    in_valid = 1'b1; drive(32'h002081B3, 0, 5, 7, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("rst.load", hold_e, 1'b0);
    out_ready = 1'b0; drive(32'h407302B3, 0, 10, 3, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk_out("rst.async", zero_e, 1'b1);
    in_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1 chk("rst.in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk_out("rst.after", zero_e, 1'b0);

    // randomized run against the model
    m_v = 1'b0; m_e = zero_e;
    for (int unsigned c = 0; c < 600; c++) begin
      logic [31:0] ri;
      ri = gen_instr();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      drive(ri, $urandom, $urandom, $urandom,
            $urandom_range(0, 1) ? ri[19:15] : ($urandom_range(0, 1) ? ri[24:20] : 5'($urandom)),
            $urandom, 1'($urandom));
      #1 chk("rnd.in_ready", 32'(in_ready), 32'(!m_v || out_ready));
      @(posedge clk);
      if (flush) m_v = 1'b0;
      else if (in_valid && (!m_v || out_ready)) begin
        m_e = ref_decode(instr, pc, rs1_data, rs2_data, rd_bypass, rd_data_bypass, reg_write_bypass);
        m_v = 1'b1;
      end else if (out_ready) m_v = 1'b0;
      #1;
      hold_e = m_e; hold_e.v = m_v;
      chk_out("rnd", hold_e, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
